// File: rtl/upcount_pkg.sv
// Shared types for the up-counting timer: FSM state encoding.
package upcount_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/upcount_core.sv
// Bare loadable n-bit up-counter: load has priority over increment.
// Wrap flags that the increment taken on this edge rolls over from 2^n-1 to 0.
module upcount_core #(
    parameter int n = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [n-1:0] R,
    input  logic         L,
    input  logic         E,
    output logic [n-1:0] Q,
    output logic         Wrap
);

    assign Wrap = E && !L && (Q == '1);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (L) begin
            Q <= R;
        end else if (E) begin
            Q <= Q + 1'b1;
        end
    end

endmodule

// File: rtl/upcount_timer.sv
// Loadable up-counting timer with start/stop, terminal limit and Done pulse.
// Define UPCOUNT_AUTO_RELOAD_EN for periodic mode (reload R at Limit, stay in RUN).
module upcount_timer
    import upcount_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [n-1:0] R,
    input  logic         L,
    input  logic         E,
    input  logic         Start,
    input  logic         Stop,
    input  logic [n-1:0] Limit,
    output logic [n-1:0] Q,
    output logic         Busy,
    output logic         Done,
    output logic         Ovf
);

    state_t state;
    state_t next_state;
    logic   core_load;
    logic   core_inc;
    logic   done_next;
    logic   wrap;
    logic   hit;

    assign hit = (Q == Limit);

    upcount_core #(.n(n)) u_core (
        .Clock (Clock),
        .Reset (Reset),
        .R     (R),
        .L     (core_load),
        .E     (core_inc),
        .Q     (Q),
        .Wrap  (wrap)
    );

    // Priority within a non-reset edge: L > Stop > Start > count.
    always_comb begin
        next_state = state;
        core_load  = 1'b0;
        core_inc   = 1'b0;
        done_next  = 1'b0;
        if (L) begin
            core_load = 1'b1;
            if (Start && state != ST_RUN) begin
                next_state = ST_RUN;
            end else if (state == ST_DONE) begin
                next_state = ST_IDLE;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) next_state = ST_RUN;
                end
                ST_RUN: begin
                    if (Stop) begin
                        next_state = ST_IDLE;
                    end else if (E) begin
                        if (hit) begin
                            done_next = 1'b1;
`ifdef UPCOUNT_AUTO_RELOAD_EN
                            core_load = 1'b1;
`else
                            next_state = ST_DONE;
`endif
                        end else begin
                            core_inc = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (Start) begin
                        core_load  = 1'b1;
                        next_state = ST_RUN;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            state <= next_state;
            Busy  <= (next_state == ST_RUN);
            Done  <= done_next;
            if (L) begin
                Ovf <= 1'b0;
            end else if (wrap) begin
                Ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_upcount_timer.sv
// Table-driven bench for upcount_timer plus a hand-written long wrap sequence.
// Honours UPCOUNT_AUTO_RELOAD_EN to select the periodic-mode expectations.
module tb_upcount_timer;

    typedef struct {
        logic       rst;
        logic       l;
        logic [7:0] r;
        logic       e;
        logic       start;
        logic       stop;
        logic [7:0] lim;
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       ovf;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] R = 8'h00;
    logic       L = 1'b0;
    logic       E = 1'b0;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic [7:0] Limit = 8'h00;
    logic [7:0] Q;
    logic       Busy;
    logic       Done;
    logic       Ovf;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    upcount_timer #(.n(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .R     (R),
        .L     (L),
        .E     (E),
        .Start (Start),
        .Stop  (Stop),
        .Limit (Limit),
        .Q     (Q),
        .Busy  (Busy),
        .Done  (Done),
        .Ovf   (Ovf)
    );

    always #5 Clock = ~Clock;

    function automatic void add(logic rst, logic l, logic [7:0] r, logic e, logic st,
                                logic sp, logic [7:0] lim, logic [7:0] q, logic b,
                                logic d, logic o);
        vec_t v;
        v.rst = rst; v.l = l; v.r = r; v.e = e; v.start = st; v.stop = sp; v.lim = lim;
        v.q = q; v.busy = b; v.done = d; v.ovf = o;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic l, input logic [7:0] r, input logic e,
                         input logic st, input logic sp, input logic [7:0] lim);
        Reset = rst; L = l; R = r; E = e; Start = st; Stop = sp; Limit = lim;
    endtask

    initial begin
        //    rst l  r    e  st sp lim   |  q   busy done ovf
        add(1, 1, 8'h55, 0, 1, 0, 0,      0,   0, 0, 0);
        add(1, 1, 8'h55, 0, 1, 0, 0,      0,   0, 0, 0);
`ifdef UPCOUNT_AUTO_RELOAD_EN
        add(0, 1, 2, 0, 0, 0, 4,          2,   0, 0, 0);
        add(0, 0, 2, 1, 1, 0, 4,          2,   1, 0, 0);
        add(0, 0, 2, 1, 0, 0, 4,          3,   1, 0, 0);
        add(0, 0, 2, 1, 0, 0, 4,          4,   1, 0, 0);
        add(0, 0, 2, 1, 0, 0, 4,          2,   1, 1, 0);
        add(0, 0, 2, 1, 0, 0, 4,          3,   1, 0, 0);
        add(0, 0, 2, 1, 0, 0, 4,          4,   1, 0, 0);
        add(0, 0, 2, 1, 0, 0, 4,          2,   1, 1, 0);
        add(0, 0, 2, 1, 0, 1, 4,          2,   0, 0, 0);
        add(0, 0, 2, 1, 0, 0, 4,          2,   0, 0, 0);
`else
        // count 5..8 then one-shot Done
        add(0, 1, 5, 0, 0, 0, 8,          5,   0, 0, 0);
        add(0, 0, 5, 1, 1, 0, 8,          5,   1, 0, 0);
        add(0, 0, 5, 1, 0, 0, 8,          6,   1, 0, 0);
        add(0, 0, 5, 1, 0, 0, 8,          7,   1, 0, 0);
        add(0, 0, 5, 1, 0, 0, 8,          8,   1, 0, 0);
        add(0, 0, 5, 1, 0, 0, 8,          8,   0, 1, 0);
        add(0, 0, 5, 1, 0, 0, 8,          8,   0, 0, 0);
        // wrap past 255 to a lower limit; L clears Ovf
        add(0, 1, 254, 0, 0, 0, 1,        254, 0, 0, 0);
        add(0, 0, 254, 1, 1, 0, 1,        254, 1, 0, 0);
        add(0, 0, 254, 1, 0, 0, 1,        255, 1, 0, 0);
        add(0, 0, 254, 1, 0, 0, 1,        0,   1, 0, 1);
        add(0, 0, 254, 1, 0, 0, 1,        1,   1, 0, 1);
        add(0, 0, 254, 1, 0, 0, 1,        1,   0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1,          0,   0, 0, 0);
        // Stop at Q==Limit beats Done; then L+Start
        add(0, 1, 5, 0, 0, 0, 200,        5,   0, 0, 0);
        add(0, 0, 5, 1, 1, 0, 200,        5,   1, 0, 0);
        add(0, 0, 5, 1, 0, 0, 200,        6,   1, 0, 0);
        add(0, 0, 5, 1, 0, 1, 6,          6,   0, 0, 0);
        add(0, 1, 3, 0, 1, 0, 200,        3,   1, 0, 0);
        // E=0 holds, then reset mid-run
        add(0, 0, 3, 0, 0, 0, 200,        3,   1, 0, 0);
        add(0, 0, 3, 0, 0, 0, 200,        3,   1, 0, 0);
        add(0, 0, 3, 0, 0, 0, 200,        3,   1, 0, 0);
        add(0, 0, 3, 0, 0, 0, 200,        3,   1, 0, 0);
        add(0, 0, 3, 1, 0, 0, 200,        4,   1, 0, 0);
        add(0, 0, 3, 1, 0, 0, 200,        5,   1, 0, 0);
        add(0, 0, 3, 1, 0, 0, 200,        6,   1, 0, 0);
        add(0, 0, 3, 1, 0, 0, 200,        7,   1, 0, 0);
        add(1, 0, 3, 1, 0, 0, 7,          0,   0, 0, 0);
        add(0, 0, 3, 1, 0, 0, 7,          0,   0, 0, 0);
        // Limit==Q at Start, restart from DONE, Stop ignored in DONE
        add(0, 1, 9, 0, 0, 0, 9,          9,   0, 0, 0);
        add(0, 0, 9, 1, 1, 0, 9,          9,   1, 0, 0);
        add(0, 0, 9, 1, 0, 0, 9,          9,   0, 1, 0);
        add(0, 0, 20, 1, 1, 0, 21,        20,  1, 0, 0);
        add(0, 0, 20, 1, 0, 0, 21,        21,  1, 0, 0);
        add(0, 0, 20, 1, 0, 0, 21,        21,  0, 1, 0);
        add(0, 0, 20, 1, 0, 1, 21,        21,  0, 0, 0);
        add(0, 0, 20, 0, 1, 0, 21,        20,  1, 0, 0);
        add(0, 0, 20, 0, 0, 0, 21,        20,  1, 0, 0);
`endif

        repeat (2) @(posedge Clock);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].l, vecs[i].r, vecs[i].e, vecs[i].start,
                  vecs[i].stop, vecs[i].lim);
            @(posedge Clock);
            #1;
            check($sformatf("v%0d_q", i), 32'(Q), 32'(vecs[i].q));
            check($sformatf("v%0d_busy", i), 32'(Busy), 32'(vecs[i].busy));
            check($sformatf("v%0d_done", i), 32'(Done), 32'(vecs[i].done));
            check($sformatf("v%0d_ovf", i), 32'(Ovf), 32'(vecs[i].ovf));
        end

`ifndef UPCOUNT_AUTO_RELOAD_EN
        // Long wrap run: 250 -> 3 needs 9 increments, Done on the 10th enabled edge.
        begin
            int  cycles;
            bit  seen;
            drive(1, 0, 0, 0, 0, 0, 0);
            @(posedge Clock); #1;
            drive(0, 1, 250, 0, 0, 0, 3);
            @(posedge Clock); #1;
            drive(0, 0, 250, 1, 1, 0, 3);
            @(posedge Clock); #1;
            check("wrap_start_q", 32'(Q), 32'd250);
            Start = 1'b0;
            cycles = 0;
            seen = 1'b0;
            while (!seen && cycles < 50) begin
                @(posedge Clock); #1;
                cycles++;
                if (Done) seen = 1'b1;
            end
            check("wrap_done_seen", 32'(seen), 32'd1);
            check("wrap_cycles", 32'(cycles), 32'd10);
            check("wrap_q", 32'(Q), 32'd3);
            check("wrap_ovf", 32'(Ovf), 32'd1);
            check("wrap_busy", 32'(Busy), 32'd0);
            @(posedge Clock); #1;
            check("wrap_done_single", 32'(Done), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
